dmem_access_unit: RTL

Parametrised, pipelined data-memory access unit between the load/store unit (LSU) queue and the data memory port. It supports up to `MAX_OUTSTANDING` in-flight requests with in-order responses, sub-word accesses (byte, half, word), sign/zero extension, byte-enable generation and misalignment detection. Speculative squash behaves as in the existing single-request unit. Load results go out on the load CDB in the cycle their memory response returns.

---
 rtl/dmem_access_unit_if.sv | 32 +++
 rtl/dmem_access_unit.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/dmem_access_unit_if.sv
// Shared types for the data-memory access unit and the memory-port interface
// that groups its request/response bus.
package dmem_pkg;
  typedef logic [31:0] word32_t;
  typedef logic [4:0]  rs_tag_t;

  localparam rs_tag_t NO_VAL = '0;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;

  typedef struct packed {
    rs_tag_t tag;
    word32_t val;
  } cdb_t;
endpackage

interface dmem_access_unit_if;
  import dmem_pkg::*;

  logic       req;
  logic       we;
  logic [3:0] be;
  word32_t    addr;
  word32_t    wdata;
  logic       ready;
  logic       rvalid;
  word32_t    rdata;

  modport master (output req, we, be, addr, wdata, input ready, rvalid, rdata);
  modport slave  (input req, we, be, addr, wdata, output ready, rvalid, rdata);
endinterface

// File: rtl/dmem_access_unit.sv
// Pipelined data-memory access unit: issues LSU heads to the memory port and
// returns load results on the CDB in response order.
module dmem_access_unit
  import dmem_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic    clk_i,
  input  logic    reset_i,
  input  logic    lsu_empty_i,
  input  logic    lsu_instr_ready_i,
  input  logic    lsu_load_i,
  input  logic [1:0] lsu_size_i,
  input  logic    lsu_unsigned_i,
  input  word32_t lsu_eff_addr_i,
  input  word32_t lsu_st_data_i,
  input  rs_tag_t lsu_ld_tag_i,
  input  logic    lsu_specultative_i,
  input  logic    lsu_corr_pred_i,
  output logic    lsu_read_o,
  output cdb_t    cdb_load_o,
  output logic    misalign_o,
  output rs_tag_t misalign_tag_o,
  dmem_access_unit_if.master dmem
);
  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(MAX_OUTSTANDING);

  typedef struct packed {
    logic       is_load;
    rs_tag_t    tag;
    logic [1:0] size;
    logic       uns;
    logic [1:0] off;
  } entry_t;

  entry_t           fifo [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;

  logic       req_q, we_q, mis_q;
  logic [3:0] be_q;
  word32_t    addr_q, data_q;
  rs_tag_t    mis_tag_q;

  logic head_valid, squash, misaligned, accept, resp_pop, room, capture;
  logic [3:0] be_next;
  word32_t    data_next, shifted, load_val;
  entry_t     head_e;

  assign head_valid = ~lsu_empty_i & lsu_instr_ready_i;
  assign squash     = head_valid & lsu_specultative_i & ~lsu_corr_pred_i;
  // Reserved size 11 is treated as a word, hence the size[1] test.
  assign misaligned = head_valid & ~squash &
                      (((lsu_size_i == SZ_HALF) & lsu_eff_addr_i[0]) |
                       (lsu_size_i[1] & (lsu_eff_addr_i[1:0] != 2'b00)));
  assign accept     = req_q & dmem.ready;
  assign resp_pop   = dmem.rvalid & (count != '0);
  assign room       = (count < FULL) | resp_pop;
  assign capture    = head_valid & ~squash & ~misaligned & (~req_q | accept) & room;

  // NOTE: the pop is gated by reset so the LSU never loses a head while the unit is held.
  assign lsu_read_o = ~reset_i & (squash | misaligned | capture);

  always_comb begin
    be_next   = 4'b1111;
    data_next = lsu_st_data_i;
    case (lsu_size_i)
      SZ_BYTE: begin
        be_next   = 4'b0001 << lsu_eff_addr_i[1:0];
        data_next = {4{lsu_st_data_i[7:0]}};
      end
      SZ_HALF: begin
        be_next   = 4'b0011 << lsu_eff_addr_i[1:0];
        data_next = {2{lsu_st_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  assign head_e  = fifo[rd_ptr];
  assign shifted = dmem.rdata >> {head_e.off, 3'b000};

  always_comb begin
    load_val = shifted;
    case (head_e.size)
      SZ_BYTE: load_val = {{24{~head_e.uns & shifted[7]}}, shifted[7:0]};
      SZ_HALF: load_val = {{16{~head_e.uns & shifted[15]}}, shifted[15:0]};
      default: ;
    endcase
    cdb_load_o.tag = (resp_pop & head_e.is_load) ? head_e.tag : NO_VAL;
    cdb_load_o.val = load_val;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      be_q      <= 4'b0000;
      addr_q    <= '0;
      data_q    <= '0;
      mis_q     <= 1'b0;
      mis_tag_q <= NO_VAL;
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else begin
      if (capture) begin
        req_q  <= 1'b1;
        we_q   <= ~lsu_load_i;
        be_q   <= be_next;
        addr_q <= {lsu_eff_addr_i[31:2], 2'b00};
        data_q <= data_next;
      end else if (accept) begin
        req_q <= 1'b0;
      end

      mis_q     <= misaligned;
      mis_tag_q <= (misaligned & lsu_load_i) ? lsu_ld_tag_i : NO_VAL;

      if (capture)  wr_ptr <= wr_ptr + PTR_W'(1);
      if (resp_pop) rd_ptr <= rd_ptr + PTR_W'(1);

      case ({capture, resp_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // NOTE: FIFO storage is not reset; only entries below the count are ever read.
  always_ff @(posedge clk_i) begin
    if (capture)
      fifo[wr_ptr] <= '{lsu_load_i, lsu_ld_tag_i, lsu_size_i, lsu_unsigned_i,
                        lsu_eff_addr_i[1:0]};
  end

  assign dmem.req   = req_q;
  assign dmem.we    = we_q;
  assign dmem.be    = be_q;
  assign dmem.addr  = addr_q;
  assign dmem.wdata = data_q;

  assign misalign_o     = mis_q;
  assign misalign_tag_o = mis_tag_q;
endmodule
